// File: rtl/axi_write_responder_if.sv
// -----------------------------------------------------------------------------
// AXI_BUS -- AXI4 bus bundle (write and read channels) used to connect the
// write responder to a master.
//
// Parameters:
//   AXI_ADDR_WIDTH  address width
//   AXI_DATA_WIDTH  data width (strobe width is AXI_DATA_WIDTH/8)
//   AXI_ID_WIDTH    transaction ID width
//   AXI_USER_WIDTH  user sideband width
//
// Modports:
//   Master  drives AW/W/AR payload+valid and B/R ready
//   Slave   drives AW/W/AR ready and B/R payload+valid
// -----------------------------------------------------------------------------
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_USER_WIDTH = 8
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    // Write address channel
    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic [2:0]                aw_prot;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    // Write data channel
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    // Write response channel
    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    // Read address channel
    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic [2:0]                ar_prot;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    // Read data channel
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_write_responder.sv
// -----------------------------------------------------------------------------
// axi_write_responder -- AXI4 write-side endpoint. Accepts one AW burst at a
// time, consumes its W beats, and returns B responses in AW order through a
// small in-order queue. Reads are not served (AR never ready, R never valid).
//
// Parameters:
//   AXI_ADDR_WIDTH / AXI_DATA_WIDTH / AXI_ID_WIDTH / AXI_USER_WIDTH  bus widths
//   MAX_PENDING  writes accepted on AW and not yet completed on B (>= 1)
//
// Ports:
//   clk_i         clock, all state updates on its rising edge
//   rst_ni        asynchronous active-low reset
//   slv           AXI_BUS Slave modport
//   wr_count_o    number of completed B handshakes (wraps at 2^32)
//   last_wdata_o  data of the most recently accepted W beat
//
// Build option:
//   AXI_WRITE_RESPONDER_LAST_CHECK_EN  when defined, a burst whose w_last
//   pattern does not mark exactly the final beat is answered with SLVERR;
//   otherwise w_last is ignored and every burst is answered with OKAY.
// -----------------------------------------------------------------------------
module axi_write_responder #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_USER_WIDTH = 8,
    parameter int unsigned MAX_PENDING    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    AXI_BUS.Slave                     slv,
    output logic [31:0]               wr_count_o,
    output logic [AXI_DATA_WIDTH-1:0] last_wdata_o
);

    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
    localparam int unsigned PTR_W  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Goes high on the first clock edge after reset release; keeps aw_ready
    // low until then.
    logic init_q;

    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [7:0]                len_q;
    logic [7:0]                beat_q;
    logic [PEND_W-1:0]         pending_q, pending_d;

    logic [PTR_W-1:0]          bq_wr_ptr_q, bq_rd_ptr_q;
    logic [PEND_W-1:0]         bq_cnt_q, bq_cnt_d;
    logic [AXI_ID_WIDTH-1:0]   bq_id_q   [MAX_PENDING];
    logic [1:0]                bq_resp_q [MAX_PENDING];

    logic [31:0]               wr_count_q;
    logic [AXI_DATA_WIDTH-1:0] last_wdata_q;

    logic                      aw_ready;
    logic                      w_ready;
    logic                      b_valid;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      b_hs;
    logic                      burst_end;
    logic [1:0]                push_resp;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_PENDING - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Handshakes. Ready/valid outputs depend on registers only, so none of
    // these create a combinational path from an input back to an output.
    // ------------------------------------------------------------------
    assign aw_hs     = slv.aw_valid & aw_ready;
    assign w_hs      = slv.w_valid & w_ready;
    assign b_valid   = (bq_cnt_q != '0);
    assign b_hs      = b_valid & slv.b_ready;
    assign burst_end = w_hs & (beat_q == len_q);

    // ------------------------------------------------------------------
    // W-phase FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // W-phase FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (aw_hs)     state_d = DATA;
            DATA:    if (burst_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // W-phase FSM: outputs. A slot for the B response is reserved at AW
    // acceptance, so limiting AW by pending also keeps the B queue from
    // overflowing.
    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        unique case (state_q)
            IDLE:    aw_ready = init_q & (pending_q < PEND_W'(MAX_PENDING));
            DATA:    w_ready  = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Response code for the burst being terminated
    // ------------------------------------------------------------------
`ifdef AXI_WRITE_RESPONDER_LAST_CHECK_EN
    // err_q remembers a w_last seen before the final beat; the final beat
    // itself must carry w_last.
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (aw_hs) begin
            err_q <= 1'b0;
        end else if (w_hs && slv.w_last && (beat_q != len_q)) begin
            err_q <= 1'b1;
        end
    end

    assign push_resp = (err_q | ~slv.w_last) ? RESP_SLVERR : RESP_OKAY;
`else
    logic unused_w_last;
    assign unused_w_last = slv.w_last;
    assign push_resp     = RESP_OKAY;
`endif

    // ------------------------------------------------------------------
    // Burst tracking, pending count, counters
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        unique case ({aw_hs, b_hs})
            2'b10:   pending_d = pending_q + PEND_W'(1);
            2'b01:   pending_d = pending_q - PEND_W'(1);
            default: ;
        endcase
    end

    always_comb begin
        bq_cnt_d = bq_cnt_q;
        unique case ({burst_end, b_hs})
            2'b10:   bq_cnt_d = bq_cnt_q + PEND_W'(1);
            2'b01:   bq_cnt_d = bq_cnt_q - PEND_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q       <= 1'b0;
            id_q         <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            pending_q    <= '0;
            bq_wr_ptr_q  <= '0;
            bq_rd_ptr_q  <= '0;
            bq_cnt_q     <= '0;
            wr_count_q   <= '0;
            last_wdata_q <= '0;
        end else begin
            init_q    <= 1'b1;
            pending_q <= pending_d;
            bq_cnt_q  <= bq_cnt_d;

            if (aw_hs) begin
                id_q   <= slv.aw_id;
                len_q  <= slv.aw_len;
                beat_q <= '0;
            end else if (w_hs) begin
                beat_q <= beat_q + 8'd1;
            end

            if (w_hs) begin
                last_wdata_q <= slv.w_data;
            end

            if (burst_end) begin
                bq_wr_ptr_q <= ptr_inc(bq_wr_ptr_q);
            end

            if (b_hs) begin
                bq_rd_ptr_q <= ptr_inc(bq_rd_ptr_q);
                wr_count_q  <= wr_count_q + 32'd1;
            end
        end
    end

    // Queue storage carries no reset: an entry is only visible while the
    // count says it is valid, and the count is reset.
    always_ff @(posedge clk_i) begin
        if (burst_end) begin
            bq_id_q[bq_wr_ptr_q]   <= id_q;
            bq_resp_q[bq_wr_ptr_q] <= push_resp;
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------
    assign slv.aw_ready = aw_ready;
    assign slv.w_ready  = w_ready;
    assign slv.b_valid  = b_valid;
    assign slv.b_id     = bq_id_q[bq_rd_ptr_q];
    assign slv.b_resp   = bq_resp_q[bq_rd_ptr_q];
    assign slv.b_user   = {AXI_USER_WIDTH{1'b0}};

    assign slv.ar_ready = 1'b0;
    assign slv.r_valid  = 1'b0;
    assign slv.r_id     = {AXI_ID_WIDTH{1'b0}};
    assign slv.r_data   = {AXI_DATA_WIDTH{1'b0}};
    assign slv.r_resp   = RESP_OKAY;
    assign slv.r_last   = 1'b0;
    assign slv.r_user   = {AXI_USER_WIDTH{1'b0}};

    assign wr_count_o   = wr_count_q;
    assign last_wdata_o = last_wdata_q;

    // Inputs that carry no meaning for this endpoint.
    logic [AXI_ADDR_WIDTH-1:0] unused_aw_addr;
    logic                      unused_misc;
    assign unused_aw_addr = slv.aw_addr;
    assign unused_misc    = ^{slv.aw_size, slv.aw_burst, slv.aw_prot, slv.aw_user,
                              slv.w_strb, slv.w_user,
                              slv.ar_id, slv.ar_addr, slv.ar_len, slv.ar_size,
                              slv.ar_burst, slv.ar_prot, slv.ar_user, slv.ar_valid,
                              slv.r_ready};

endmodule

// File: tb/tb_axi_write_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_write_responder -- self-checking bench for axi_write_responder.
// Inputs are driven and outputs sampled on the falling clock edge. A queue of
// expected {id, resp} entries is filled as bursts complete and drained by the
// B-channel monitor, which compares every response in order.
// -----------------------------------------------------------------------------
module tb_axi_write_responder;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned IW   = 8;
    localparam int unsigned UW   = 8;
    localparam int unsigned MAXP = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   wr_count;
    logic [DW-1:0] last_wdata;

    AXI_BUS #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .AXI_USER_WIDTH (UW)
    ) bus ();

    axi_write_responder #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .AXI_USER_WIDTH (UW),
        .MAX_PENDING    (MAXP)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .slv          (bus),
        .wr_count_o   (wr_count),
        .last_wdata_o (last_wdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // B-channel monitor / scoreboard
    // b_mode: 0 = b_ready low, 1 = b_ready high, 2 = random
    // ------------------------------------------------------------------
    int            b_mode = 0;
    logic [9:0]    exp_q[$];          // {id, resp} in expected completion order
    int unsigned   b_done = 0;
    int unsigned   b_cyc_log[$];
    bit            stall_q = 1'b0;
    logic [IW-1:0] stall_id = '0;

    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst_n) begin
            bus.b_ready = 1'b0;
            stall_q     = 1'b0;
        end else begin
            case (b_mode)
                0:       bus.b_ready = 1'b0;
                1:       bus.b_ready = 1'b1;
                default: bus.b_ready = 1'($urandom_range(0, 1));
            endcase
            if (stall_q) begin
                check_eq("b_hold_valid", bus.b_valid, 1);
                check_eq("b_hold_id", bus.b_id, stall_id);
            end
            if (bus.b_valid && bus.b_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("b_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("b_id", bus.b_id, e[9:2]);
                    check_eq("b_resp", bus.b_resp, e[1:0]);
                end
                b_done++;
                b_cyc_log.push_back(cyc);
                $display("B  id=0x%02h resp=%0d cycle=%0d", bus.b_id, bus.b_resp, cyc);
            end
            stall_q  = bus.b_valid && !bus.b_ready;
            stall_id = bus.b_id;
        end
    end

    // ------------------------------------------------------------------
    // Write driver. lmode: 0 = correct w_last, 1 = w_last never set,
    // 2 = randomly corrupted. stop_at >= 0 abandons the burst after that
    // many accepted beats (no response expected).
    // ------------------------------------------------------------------
    int unsigned aw_hs_cyc = 0;

    task automatic do_write(input logic [IW-1:0] id, input logic [7:0] len,
                            input logic [DW-1:0] data0, input bit rnd_data,
                            input int lmode, input bit gaps, input int stop_at);
        int            n;
        int            beats;
        int            want_beats;
        bit            err;
        bit            want_last;
        logic [DW-1:0] d;
        logic [DW-1:0] last_d;
        logic [1:0]    resp;

        @(negedge clk);
        bus.aw_valid = 1'b1;
        bus.aw_id    = id;
        bus.aw_len   = len;
        bus.aw_addr  = $urandom;
        bus.aw_size  = 3'd2;
        bus.aw_burst = 2'b01;
        bus.aw_prot  = 3'($urandom);
        bus.aw_user  = 8'($urandom);
        n = 0;
        while (!bus.aw_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("aw_accept", bus.aw_ready, 1);
        aw_hs_cyc = cyc;
        @(negedge clk);
        bus.aw_valid = 1'b0;

        beats  = 0;
        err    = 1'b0;
        last_d = '0;
        n      = 0;
        want_beats = (stop_at >= 0) ? stop_at : int'(len) + 1;
        while (beats < want_beats && n < 1000) begin
            bus.w_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            d = rnd_data ? DW'($urandom) : data0;
            bus.w_data = d;
            bus.w_strb = 4'($urandom);
            bus.w_user = 8'($urandom);
            want_last = (beats == int'(len));
            case (lmode)
                0:       bus.w_last = want_last;
                1:       bus.w_last = 1'b0;
                default: bus.w_last = want_last ^ ($urandom_range(0, 7) == 0);
            endcase
            if (bus.w_valid && bus.w_ready) begin
                if (bus.w_last != want_last) err = 1'b1;
                last_d = d;
                beats++;
                if (beats == int'(len) + 1) begin
`ifdef AXI_WRITE_RESPONDER_LAST_CHECK_EN
                    resp = err ? 2'b10 : 2'b00;
`else
                    resp = 2'b00;
`endif
                    exp_q.push_back({id, resp});
                end
            end
            @(negedge clk);
            n++;
        end
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
        check_eq("w_beats", beats, want_beats);
        if (stop_at < 0) begin
            check_eq("w_ready_after_last", bus.w_ready, 0);
            check_eq("last_wdata", last_wdata, last_d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned lat;
        int          n;

        bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
        bus.aw_size = '0; bus.aw_burst = '0; bus.aw_prot = '0; bus.aw_user = '0;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
        bus.w_user = '0;
        bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
        bus.ar_size = '0; bus.ar_burst = '0; bus.ar_prot = '0; bus.ar_user = '0;
        bus.r_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_aw_ready", bus.aw_ready, 0);
        check_eq("rst_w_ready", bus.w_ready, 0);
        check_eq("rst_b_valid", bus.b_valid, 0);
        check_eq("rst_wr_count", wr_count, 0);
        check_eq("rst_last_wdata", last_wdata, 0);
        check_eq("b_user_zero", bus.b_user, 0);
        check_eq("ar_ready_zero", bus.ar_ready, 0);
        check_eq("r_valid_zero", bus.r_valid, 0);
        #2 rst_n = 1'b1;
        #1 check_eq("aw_ready_before_edge", bus.aw_ready, 0);
        @(negedge clk);
        check_eq("aw_ready_after_edge", bus.aw_ready, 1);

        // Single write: B two cycles after AW
        b_mode = 1;
        base = b_done;
        do_write(8'h5A, 8'd0, 32'hcafebabe, 1'b0, 0, 1'b0, -1);
        repeat (3) @(negedge clk);
        check_eq("single_b_count", b_done - base, 1);
        lat = (b_cyc_log.size() > base) ? b_cyc_log[base] - aw_hs_cyc : 32'hFFFF_FFFF;
        check_eq("single_b_latency", lat, 2);
        check_eq("single_wr_count", wr_count, 1);
        check_eq("single_last_wdata", last_wdata, 32'hcafebabe);

        // Burst of 4 beats with random w_valid gaps
        base = b_done;
        do_write(8'($urandom), 8'd3, '0, 1'b1, 0, 1'b1, -1);
        repeat (4) @(negedge clk);
        check_eq("burst_b_count", b_done - base, 1);
        check_eq("burst_wr_count", wr_count, 2);

        // Back-pressure: four writes fill pending, fifth waits for a B
        b_mode = 0;
        for (int i = 1; i <= 4; i++) begin
            do_write(8'(i), 8'd0, '0, 1'b1, 0, 1'b0, -1);
        end
        check_eq("aw_ready_full", bus.aw_ready, 0);
        check_eq("b_valid_full", bus.b_valid, 1);
        base = b_done;
        fork
            do_write(8'd5, 8'd0, '0, 1'b1, 0, 1'b0, -1);
            begin
                repeat (3) @(posedge clk);
                b_mode = 1;
            end
        join
        lat = (b_cyc_log.size() > base) ? aw_hs_cyc - b_cyc_log[base] : 32'hFFFF_FFFF;
        check_eq("fifth_aw_after_b", lat, 1);
        repeat (10) @(negedge clk);
        check_eq("full_b_count", b_done - base, 5);
        check_eq("full_wr_count", wr_count, 7);

        // Missing w_last on the terminating beat
        base = b_done;
        do_write(8'h33, 8'd1, '0, 1'b1, 1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check_eq("last_b_count", b_done - base, 1);
        check_eq("last_wr_count", wr_count, 8);

        // Reset with a queued response and a burst mid-DATA
        b_mode = 0;
        do_write(8'h77, 8'd0, '0, 1'b1, 0, 1'b0, -1);
        do_write(8'h78, 8'd3, '0, 1'b1, 0, 1'b0, 2);
        check_eq("pre_rst_b_valid", bus.b_valid, 1);
        check_eq("pre_rst_w_ready", bus.w_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_b_valid", bus.b_valid, 0);
        check_eq("mid_rst_w_ready", bus.w_ready, 0);
        check_eq("mid_rst_aw_ready", bus.aw_ready, 0);
        check_eq("mid_rst_wr_count", wr_count, 0);
        check_eq("mid_rst_last_wdata", last_wdata, 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        b_mode = 1;
        base = b_done;
        do_write(8'h99, 8'd2, '0, 1'b1, 0, 1'b1, -1);
        repeat (5) @(negedge clk);
        check_eq("post_rst_b_count", b_done - base, 1);
        check_eq("post_rst_wr_count", wr_count, 1);

        // 200 randomized writes from a clean reset
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        b_mode = 2;
        base = b_done;
        for (int i = 0; i < 200; i++) begin
            do_write(8'($urandom), 8'($urandom_range(0, 7)), '0, 1'b1, 2,
                     1'($urandom_range(0, 1)), -1);
        end
        b_mode = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check_eq("rand_drained", exp_q.size(), 0);
        check_eq("rand_b_count", b_done - base, 200);
        check_eq("rand_wr_count", wr_count, 200);
        check_eq("rand_b_valid_idle", bus.b_valid, 0);
        check_eq("rand_aw_ready_idle", bus.aw_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
